// File: rtl/custom_types.sv
// -----------------------------------------------------------------------------
// custom_types
// Shared types for the memory responder slice.
//   resp_state_t : responder FSM states (IDLE, WAIT, RESP)
//   CNT_W        : width of the wait-state counter (covers 0..15 wait states)
// -----------------------------------------------------------------------------
package custom_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/wait_counter.sv
// -----------------------------------------------------------------------------
// wait_counter
// Loadable down-counter that times the wait states of the responder.
//   clk      : clock, rising edge
//   reset    : asynchronous, active-low; clears the count to 0
//   load     : load load_val (takes priority over dec)
//   load_val : value loaded on load
//   dec      : decrement by one, saturating at 0
//   done     : count is 1, i.e. the final wait cycle is in progress
// -----------------------------------------------------------------------------
module wait_counter
    import custom_types::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    // The state that sees done leaves WAIT on the next edge, so a load of N
    // yields exactly N wait cycles.
    assign done = (count == W'(1));

endmodule

// File: rtl/mem_responder_4bit.sv
// -----------------------------------------------------------------------------
// mem_responder_4bit
// Single-outstanding request/response memory with programmable wait states.
// A request is captured in IDLE, optionally delayed WAIT_CYCLES cycles, and the
// memory is accessed once on the edge that enters RESP. The response is held
// until the initiator accepts it.
//   clk        : clock, rising edge
//   reset      : asynchronous, active-low; clears FSM, outputs and memory
//   req_valid  : request present          req_ready : request accepted (IDLE)
//   req_write  : 1 = write, 0 = read      req_addr  : word address
//   req_wdata  : write data
//   rsp_valid  : response present (RESP)  rsp_ready : initiator takes response
//   rsp_rdata  : read data, 0 for writes and errors
//   rsp_err    : address at or above MEM_DEPTH
// -----------------------------------------------------------------------------
module mem_responder_4bit
    import custom_types::*;
#(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 4,
    parameter int MEM_DEPTH   = 12,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    resp_state_t       state, state_nxt;

    logic              cap_write;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic              cnt_load, cnt_dec, cnt_done;
    logic              enter_resp;
    logic              acc_write, acc_in_range;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;

    wait_counter #(.W(CNT_W)) u_wait_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (CNT_W'(WAIT_CYCLES)),
        .dec      (cnt_dec),
        .done     (cnt_done)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_load  = 1'b1;
                    end
                end
            end
            WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_done) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_resp = (state != RESP) && (state_nxt == RESP);

    // With no wait states RESP is entered on the capture edge itself, so the
    // live request fields are exactly the ones being captured.
    assign acc_write    = (state == IDLE) ? req_write : cap_write;
    assign acc_addr     = (state == IDLE) ? req_addr  : cap_addr;
    assign acc_wdata    = (state == IDLE) ? req_wdata : cap_wdata;
    assign acc_in_range = int'(acc_addr) < MEM_DEPTH;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && req_valid) begin
                cap_write <= req_write;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
            end
        end
    end

    // NOTE: the storage array is cleared by reset here because the design
    // promises all-zero contents after reset; a plain RAM macro would not.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (enter_resp) begin
            if (!acc_in_range) begin
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end else if (acc_write) begin
                mem[acc_addr] <= acc_wdata;
                rsp_err       <= 1'b0;
                rsp_rdata     <= '0;
            end else begin
                rsp_err   <= 1'b0;
                rsp_rdata <= mem[acc_addr];
            end
        end else if ((state == RESP) && rsp_ready) begin
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end
    end

endmodule
